source_packer: RTL and testbench
================================

// Module: source_packer
// PURPOSE
// - Assembles the host byte stream (UART/FIFO side) into full source words {opcode, charges} for network_source.
// - Sits directly upstream of network_source: its src/src_valid/src_ready connect 1:1 to that block's source port.
// - Holds one completed word while the next word's bytes arrive, so a full word is not needed back-to-back to keep the network fed.
// PARAMETERS
// - WORD_WIDTH      `SRC_WIDTH  Bits per source word (OPC_WIDTH + NET_NUM_INP*NET_CHARGE_WIDTH); >= 1.
// - TIMEOUT_CYCLES  0           Idle cycles with a partial word before it is discarded; 0 disables the timeout.
// PORTS
// - clk          in   1           Single clock. All logic is posedge.
// - arstn        in   1           Asynchronous active-low reset.
// - rx_valid     in   1           Byte-stream valid.
// - rx_ready     out  1           Byte-stream ready.
// - rx_data      in   8           Byte; transfers when rx_valid && rx_ready.
// - src_valid    out  1           Completed word available.
// - src_ready    in   1           Consumer accepts word (transfer = src_valid && src_ready).
// - src          out  WORD_WIDTH  Completed word. MSB-first: opcode is in the top OPC_WIDTH bits.
// - err_timeout  out  1           One-cycle pulse when a partial word is discarded.
// BEHAVIOUR
// - NB = ceil(WORD_WIDTH/8) bytes per word; PAD = NB*8 - WORD_WIDTH.
// - Byte order is big-endian: first byte holds the word MSBs.
// - The top PAD bits of the first byte are ignored, whatever their value.
// - Reset: rx_ready=1, src_valid=0, src=0, err_timeout=0; byte index=0, timeout counter=0, assembly register=0.
// - Reset mid-word drops the partial word and any held word; no output handshake follows.
// - Assembly: byte index idx counts 0..NB-1.
//   - Each accepted byte shifts into the assembly register and increments idx.
//   - On acceptance with idx==NB-1, the full word (shift register + this byte) loads the output register, src_valid is set, and idx wraps to 0.
// - Latency: src_valid rises the cycle after the last byte of a word is accepted.
//   - src is stable and src_valid is held until the transfer completes.
// - Backpressure: rx_ready = !(idx==NB-1 && src_valid && !src_ready).
//   - Bytes 0..NB-2 of the next word are accepted while a word is held.
//   - The final byte is accepted in the same cycle the held word leaves.
//   - That case is a simultaneous load and transfer: src_valid stays 1 and src updates to the new word.
// - rx_ready depends combinationally on src_ready; no other comb path from input to output exists.
// - Output transfer without a new load clears src_valid on the next edge.
// - NB==1: every accepted byte is a complete word; the same rules apply with idx fixed at 0.
// - Timeout (TIMEOUT_CYCLES>0):
//   - Counter increments each cycle with idx!=0 and no byte accepted.
//   - Counter clears on any byte acceptance or when idx==0.
//   - When counter==TIMEOUT_CYCLES-1 and no byte is accepted that cycle: idx<=0, counter<=0, err_timeout pulses high for the next cycle.
//   - A held output word is unaffected.
//   - A byte accepted in the same cycle as expiry wins: no timeout, and that byte is assembled.
// - With TIMEOUT_CYCLES==0 the counter is absent and err_timeout is tied 0.
// - No state machine beyond idx/src_valid; CLR and NOM words pass through unmodified (opcode is not decoded here).
// STRUCTURE
// - source_config package gains localparams:
//   - BYTE_WIDTH = 8
//   - SRC_BYTES = ceil(`SRC_WIDTH/BYTE_WIDTH)
//   - SRC_PAD = SRC_BYTES*BYTE_WIDTH - `SRC_WIDTH
// - idx width = $clog2(NB) with a minimum of 1.
// - Timeout counter width = $clog2(TIMEOUT_CYCLES+1).
// - One natural sub-module: idle_timer (clear, enable, expire pulse), reusable by the sink-side unpacker.
// - Datapath (shift register, output register) stays inline.
// TESTING  (WORD_WIDTH=17 -> NB=3, PAD=7, unless stated)
// - Bytes 0xFF,0xA5,0x3C, src_ready=1 -> one src=17'h1A53C (pad bits ignored); src_valid high 1 cycle, 1 cycle after the 3rd byte.
// - src_ready=0, send 6 bytes back-to-back:
//   - rx_ready drops exactly at the 6th byte; first word held stable.
//   - Raise src_ready -> 6th byte accepted that cycle; next cycle src = 2nd word with src_valid still 1.
// - TIMEOUT_CYCLES=4: send 1 byte then idle 4 cycles -> err_timeout single pulse.
//   - A following 3-byte word then assembles correctly, with no stale byte mixed in.
// - TIMEOUT_CYCLES=4: byte arrives exactly on the expiry cycle -> no err_timeout; the word completes normally.
// - Assert arstn low after 2 bytes and with a held word:
//   - Outputs read reset values immediately (src_valid=0, src=0, rx_ready=1).
//   - After release, a clean 3-byte word is produced.
// - WORD_WIDTH=8 (NB=1), random rx_valid/src_ready over 1000 bytes -> output equals input sequence, no loss or duplication.

Source files
------------

// File: rtl/source_packer_pkg.sv
// Shared sizing for the host-to-network source word path.
// Word layout is {opcode, charges}, MSB-first, carried as big-endian bytes.
package source_packer_pkg;

    localparam int unsigned OPC_WIDTH        = 3;
    localparam int unsigned NET_NUM_INP      = 2;
    localparam int unsigned NET_CHARGE_WIDTH = 7;
    localparam int unsigned SRC_WIDTH        = OPC_WIDTH + NET_NUM_INP * NET_CHARGE_WIDTH;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned SRC_BYTES  = (SRC_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int unsigned SRC_PAD    = SRC_BYTES * BYTE_WIDTH - SRC_WIDTH;

    function automatic int unsigned bytes_for(input int unsigned width);
        return (width + BYTE_WIDTH - 1) / BYTE_WIDTH;
    endfunction

    // A single-byte word still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/source_packer_idle_timer.sv
// Idle-cycle counter: runs while enabled, restarts on clear, pulses expire on its last count.
// Shared with the sink-side unpacker.
module idle_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic arstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = enable && !clear && (cnt_q == CW'(CYCLES - 1));
        cnt_d  = cnt_q;
        if (clear || !enable || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/source_packer.sv
// Packs the host byte stream into {opcode, charges} source words for network_source,
// holding one finished word while the next one is being assembled.
module source_packer
    import source_packer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = SRC_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic [WORD_WIDTH-1:0] src,
    output logic                  err_timeout
);

    localparam int unsigned NB = bytes_for(WORD_WIDTH);
    localparam int unsigned IW = idx_width(NB);

    logic [IW-1:0]         idx_q, idx_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [WORD_WIDTH-1:0] src_q, src_d;
    logic                  src_valid_q, src_valid_d;
    logic [WORD_WIDTH-1:0] full_word;
    logic                  last_byte;
    logic                  accept;
    logic                  expire;

    assign last_byte = (idx_q == IW'(NB - 1));
    // The final byte may only land when the held word is leaving this same cycle.
    assign rx_ready  = !(last_byte && src_valid_q && !src_ready);
    assign accept    = rx_valid && rx_ready;
    // Truncating the concatenation drops the pad bits of the first byte.
    assign full_word = WORD_WIDTH'({asm_q, rx_data});

    always_comb begin
        idx_d       = idx_q;
        asm_d       = asm_q;
        src_d       = src_q;
        src_valid_d = src_valid_q;

        if (src_valid_q && src_ready) begin
            src_valid_d = 1'b0;
        end

        if (accept) begin
            asm_d = full_word;
            if (last_byte) begin
                idx_d       = '0;
                src_d       = full_word;
                src_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (expire) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            idx_q       <= '0;
            asm_q       <= '0;
            src_q       <= '0;
            src_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            src_q       <= src_d;
            src_valid_q <= src_valid_d;
        end
    end

    assign src       = src_q;
    assign src_valid = src_valid_q;

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        logic err_q;

        idle_timer #(
            .CYCLES (TIMEOUT_CYCLES)
        ) u_idle_timer (
            .clk    (clk),
            .arstn  (arstn),
            .clear  (accept),
            .enable (idx_q != '0),
            .expire (expire)
        );

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                err_q <= 1'b0;
            end else begin
                err_q <= expire;
            end
        end

        assign err_timeout = err_q;
    end else begin : g_no_timeout
        assign expire      = 1'b0;
        assign err_timeout = 1'b0;
    end

endmodule

// File: tb/tb_source_packer.sv
// Scoreboard bench: a 17-bit packer with timeout, plus an 8-bit packer under random handshakes.
module tb_source_packer;

    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    // DUT A: WORD_WIDTH=17 (NB=3, PAD=7), TIMEOUT_CYCLES=4
    logic        a_rx_valid, a_rx_ready, a_src_valid, a_src_ready, a_err;
    logic [7:0]  a_rx_data;
    logic [16:0] a_src;

    // DUT B: WORD_WIDTH=8 (NB=1), no timeout
    logic        b_rx_valid, b_rx_ready, b_src_valid, b_src_ready, b_err;
    logic [7:0]  b_rx_data;
    logic [7:0]  b_src;

    source_packer #(
        .WORD_WIDTH     (17),
        .TIMEOUT_CYCLES (4)
    ) dut_a (
        .clk         (clk),
        .arstn       (arstn),
        .rx_valid    (a_rx_valid),
        .rx_ready    (a_rx_ready),
        .rx_data     (a_rx_data),
        .src_valid   (a_src_valid),
        .src_ready   (a_src_ready),
        .src         (a_src),
        .err_timeout (a_err)
    );

    source_packer #(
        .WORD_WIDTH     (8),
        .TIMEOUT_CYCLES (0)
    ) dut_b (
        .clk         (clk),
        .arstn       (arstn),
        .rx_valid    (b_rx_valid),
        .rx_ready    (b_rx_ready),
        .rx_data     (b_rx_data),
        .src_valid   (b_src_valid),
        .src_ready   (b_src_ready),
        .src         (b_src),
        .err_timeout (b_err)
    );

    int checks = 0;
    int errors = 0;

    logic [16:0] a_q[$];
    logic [7:0]  b_q[$];
    int          a_err_cnt = 0;
    int          b_popped  = 0;
    logic        a_hold    = 1'b0;
    logic [16:0] a_prev    = '0;
    logic        b_seen_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor A: pops the scoreboard on every output transfer, checks held words stay put.
    always @(negedge clk) begin
        if (!arstn) begin
            a_hold = 1'b0;
        end else begin
            if (a_err === 1'b1) a_err_cnt++;
            if (a_src_valid && a_hold) check("a_hold_stable", 32'(a_src), 32'(a_prev));
            if (a_src_valid && a_src_ready) begin
                if (a_q.size() == 0) begin
                    check("a_unexpected_word", 32'(a_src), 32'hFFFF_FFFF);
                end else begin
                    check("a_word", 32'(a_src), 32'(a_q.pop_front()));
                end
                a_hold = 1'b0;
            end else begin
                a_hold = a_src_valid;
                a_prev = a_src;
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (arstn) begin
            if (b_err !== 1'b0) b_seen_err = 1'b1;
            if (b_src_valid && b_src_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_word", 32'(b_src), 32'hFFFF_FFFF);
                end else begin
                    check("b_word", 32'(b_src), 32'(b_q.pop_front()));
                end
                b_popped++;
            end
        end
    end

    // Offer one byte to DUT A and return just after the edge that accepts it.
    task automatic send_a(input logic [7:0] b);
        int n = 0;
        a_rx_valid = 1'b1;
        a_rx_data  = b;
        forever begin
            @(negedge clk);
            if (a_rx_ready) break;
            n++;
            if (n > 50) begin
                check("a_rx_ready_timeout", 32'(a_rx_ready), 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_rx_valid = 1'b0;
    endtask

    initial begin
        int wait_n;
        int sent;
        int cyc;
        logic       pend;
        logic [7:0] bdat;

        arstn       = 1'b0;
        a_rx_valid  = 1'b0;
        a_rx_data   = '0;
        a_src_ready = 1'b1;
        b_rx_valid  = 1'b0;
        b_rx_data   = '0;
        b_src_ready = 1'b0;
        #12;
        check("reset_rx_ready", 32'(a_rx_ready), 32'h1);
        check("reset_src_valid", 32'(a_src_valid), 32'h0);
        check("reset_src", 32'(a_src), 32'h0);
        check("reset_err", 32'(a_err), 32'h0);
        arstn = 1'b1;
        @(posedge clk);
        #1;

        // Pad bits of the first byte are ignored.
        a_q.push_back(17'h1A53C);
        send_a(8'hFF);
        send_a(8'hA5);
        send_a(8'h3C);
        check("t1_valid_rise", 32'(a_src_valid), 32'h1);
        check("t1_src", 32'(a_src), 32'h1A53C);
        @(posedge clk);
        #1;
        check("t1_valid_one_cycle", 32'(a_src_valid), 32'h0);

        // Backpressure: six bytes with the consumer stalled.
        a_src_ready = 1'b0;
        a_q.push_back(17'h12345);
        a_q.push_back(17'h1ABCD);
        send_a(8'h01);
        send_a(8'h23);
        send_a(8'h45);
        send_a(8'h81);
        send_a(8'hAB);
        a_rx_valid = 1'b1;
        a_rx_data  = 8'hCD;
        @(negedge clk);
        check("t2_rx_ready_low", 32'(a_rx_ready), 32'h0);
        check("t2_held_src", 32'(a_src), 32'h12345);
        check("t2_held_valid", 32'(a_src_valid), 32'h1);
        @(negedge clk);
        check("t2_rx_ready_low2", 32'(a_rx_ready), 32'h0);
        @(posedge clk);
        #1;
        a_src_ready = 1'b1;
        @(negedge clk);
        check("t2_rx_ready_comb", 32'(a_rx_ready), 32'h1);
        @(posedge clk);
        #1;
        a_rx_valid = 1'b0;
        check("t2_valid_stays", 32'(a_src_valid), 32'h1);
        check("t2_src_next", 32'(a_src), 32'h1ABCD);
        repeat (2) @(posedge clk);
        #1;

        // Timeout: one byte then idle.
        send_a(8'h77);
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_err_early", 32'(a_err), 32'h0);
        @(posedge clk);
        #1;
        check("t3_err_pulse", 32'(a_err), 32'h1);
        @(posedge clk);
        #1;
        check("t3_err_single", 32'(a_err), 32'h0);
        a_q.push_back(17'h13456);
        send_a(8'h13);
        send_a(8'h34);
        send_a(8'h56);
        repeat (2) @(posedge clk);
        #1;

        // Byte arriving on the expiry cycle wins.
        send_a(8'h99);
        repeat (3) @(posedge clk);
        #1;
        a_q.push_back(17'h155AA);
        send_a(8'h55);
        check("t4_no_err", 32'(a_err), 32'h0);
        send_a(8'hAA);
        repeat (6) @(posedge clk);
        #1;
        check("t4_err_total", 32'(a_err_cnt), 32'h1);

        // Reset mid-word, then with a held word.
        send_a(8'h11);
        send_a(8'h22);
        #1;
        arstn = 1'b0;
        #1;
        check("t5_rst_rx_ready", 32'(a_rx_ready), 32'h1);
        check("t5_rst_valid", 32'(a_src_valid), 32'h0);
        @(posedge clk);
        #1;
        arstn       = 1'b1;
        a_src_ready = 1'b0;
        @(posedge clk);
        #1;
        send_a(8'h1F);
        send_a(8'hFF);
        send_a(8'hFF);
        check("t5_held_before_rst", 32'(a_src), 32'h1FFFF);
        #1;
        arstn = 1'b0;
        #1;
        check("t5_rst2_valid", 32'(a_src_valid), 32'h0);
        check("t5_rst2_src", 32'(a_src), 32'h0);
        check("t5_rst2_rx_ready", 32'(a_rx_ready), 32'h1);
        @(posedge clk);
        #1;
        arstn       = 1'b1;
        a_src_ready = 1'b1;
        @(posedge clk);
        #1;
        a_q.push_back(17'h1468A);
        send_a(8'h03);
        send_a(8'h46);
        send_a(8'h8A);
        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(a_q.size()), 32'h0);

        // NB=1: random handshakes, output must equal input sequence.
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        bdat = '0;
        while (sent < 1000 && cyc < 20000) begin
            @(posedge clk);
            #1;
            b_src_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                bdat = 8'($urandom);
                pend = 1'b1;
            end
            b_rx_valid = 1'($urandom_range(0, 1));
            b_rx_data  = bdat;
            @(negedge clk);
            if (b_rx_valid && b_rx_ready) begin
                b_q.push_back(bdat);
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        b_rx_valid  = 1'b0;
        b_src_ready = 1'b1;
        wait_n = 0;
        while (b_q.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        #1;
        check("b_sent", 32'(sent), 32'd1000);
        check("b_popped", 32'(b_popped), 32'd1000);
        check("b_queue_drained", 32'(b_q.size()), 32'h0);
        check("b_err_tied", 32'(b_seen_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
